// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full-subtractor cell plus a registered borrow, LSB-first over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bin_q, bin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic             x, y, d_bit, bout;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell on the current operand LSBs
  assign x        = a_sh_q[0];
  assign y        = b_sh_q[0];
  assign d_bit    = x ^ y ^ bin_q;
  assign bout     = (~x & y) | (~(x ^ y) & bin_q);
  assign res_next = {d_bit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    diff_d   = diff_q;
    bin_d    = bin_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = res_next;
        bin_d  = bout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Final bit: publish result, the last d_bit is the result MSB
          diff_d   = res_next;
          borrow_d = bout;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          cnt_d    = '0;
          state_d  = IDLE;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      bin_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      bin_q    <= bin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8) with a result scoreboard.
module tb_serial_sub;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;
  logic         ovf;

  int checks = 0;
  int fails = 0;
  int done_cnt = 0;
  int cyc = 0;
  exp_t q[$];

`ifndef SERIAL_SUB_OVF_EN
  assign ovf = 1'b0;
`endif

  serial_sub #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf        (ovf),
`endif
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    e.diff   = av - bv;
    e.borrow = (av < bv);
    e.ovf    = (av[W-1] != bv[W-1]) && (e.diff[W-1] != av[W-1]);
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      done_cnt++;
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: diff=%02h with no request outstanding", diff);
      end else begin
        e = q.pop_front();
        if (diff !== e.diff || borrow_out !== e.borrow) begin
          fails++;
          $display("FAIL result: got diff=%02h borrow=%0b, want diff=%02h borrow=%0b",
                   diff, borrow_out, e.diff, e.borrow);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== e.ovf) begin
          fails++;
          $display("FAIL ovf: got %0b want %0b", ovf, e.ovf);
        end
`endif
        checks++;
        if (busy !== 1'b0) begin
          fails++;
          $display("FAIL busy_at_done: got %0b want 0", busy);
        end
      end
    end
  end

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL %s_timeout: done=%0b after %0d cycles, want 1", name, done, n);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL %s: got busy=%0b done=%0b diff=%02h borrow=%0b ovf=%0b, want all 0",
               name, busy, done, diff, borrow_out, ovf);
    end
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string name);
    int n;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    q.push_back(model(av, bv));
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL %s_busy: got %0b want 1", name, busy);
    end
    wait_done(name, n);
    checks++;
    if (n != W) begin
      fails++;
      $display("FAIL %s_latency: got %0d cycles want %0d", name, n, W);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL %s_done_pulse: done=%0b one cycle later, want 0", name, done);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_zero("reset_values");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("idle_after_reset");
  endtask

  task automatic test_basic();
    run_op(8'h05, 8'h03, "sub_5_3");
    run_op(8'h03, 8'h05, "sub_3_5");
    run_op(8'h80, 8'h01, "sub_80_01");
    run_op(8'h00, 8'hFF, "sub_00_ff");
    for (int i = 0; i < 4; i++) run_op(W'($urandom), W'($urandom), "sub_rand");
  endtask

  task automatic test_back_to_back();
    int n;
    int t [3];
    @(negedge clk);
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    for (int i = 0; i < 3; i++) q.push_back(model(8'hFF, 8'hFF));
    for (int i = 0; i < 3; i++) begin
      wait_done("b2b", n);
      t[i] = cyc;
      if (i > 0) begin
        checks++;
        if (t[i] - t[i-1] != W + 1) begin
          fails++;
          $display("FAIL b2b_period: got %0d cycles want %0d", t[i] - t[i-1], W + 1);
        end
      end
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || q.size() != 0) begin
      fails++;
      $display("FAIL b2b_drain: busy=%0b pending=%0d, want 0/0", busy, q.size());
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    a = 8'h40;
    b = 8'h11;
    start = 1'b1;
    q.push_back(model(8'h40, 8'h11));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF;
    b = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_ignore", n);
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL busy_ignore_pulses: got %0d done pulses want 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    @(negedge clk);
    a = 8'h77;
    b = 8'h22;
    start = 1'b1;
    q.push_back(model(8'h77, 8'h22));
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_outputs");
    q.delete();
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt != d0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_no_done: got %0d pulses want 0", done_cnt - d0);
    end
    run_op(8'h10, 8'h20, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d results outstanding, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
